// File: rtl/fetch_unit.sv
// Fetch unit: PC/MAR/MBR/IR datapath with a RAM read wait-state FSM and a sticky protocol-error flag.
// Optional macro FU_INSTR_COUNT_EN adds a 16-bit count of accepted IR loads on output instr_cnt.
module fetch_unit #(
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic        FU_clk,
  input  logic        FU_rst,
  input  logic        PC_inc,
  input  logic        MAR_we,
  input  logic        MAR_mux,
  input  logic        MBR_we,
  input  logic        MBR_mux,
  input  logic        IR_we,
  input  logic        RAM_we,
  input  logic [7:0]  RF_in,
  input  logic [7:0]  ram_rdata,
  output logic [7:0]  ram_addr,
  output logic [7:0]  ram_wdata,
  output logic        ram_we,
  output logic [7:0]  IR_out,
  output logic [7:0]  PC_out,
  output logic        FU_busy,
  output logic        FU_err
`ifdef FU_INSTR_COUNT_EN
  ,
  output logic [15:0] instr_cnt
`endif
);

  typedef enum logic {
    S_IDLE,
    S_WAIT
  } state_t;

  localparam logic [1:0] LP_CNT_INIT = (WAIT_CYCLES == 0) ? 2'd0 : 2'(WAIT_CYCLES - 1);

  state_t     r_state;
  logic [1:0] r_cnt;
  logic [7:0] r_pc;
  logic [7:0] r_mar;
  logic [7:0] r_mbr;
  logic [7:0] r_ir;
  logic       r_err;
  logic       w_busy;
  logic       w_any_strobe;
`ifdef FU_INSTR_COUNT_EN
  logic [15:0] r_instr_cnt;
`endif

  assign w_busy       = (r_state == S_WAIT);
  assign w_any_strobe = MAR_we | MBR_we | IR_we | RAM_we;

  always_ff @(posedge FU_clk or posedge FU_rst) begin
    if (FU_rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_pc    <= '0;
      r_mar   <= '0;
      r_mbr   <= '0;
      r_ir    <= '0;
      r_err   <= 1'b0;
`ifdef FU_INSTR_COUNT_EN
      r_instr_cnt <= '0;
`endif
    end else begin
      // NOTE: non-blocking assignments make every right-hand side the pre-edge value, so
      // MAR sees the old PC and IR sees the old MBR when strobes coincide.
      if (PC_inc) r_pc <= r_pc + 8'd1;

      case (r_state)
        S_IDLE: begin
          if (MAR_we) r_mar <= MAR_mux ? {4'h0, r_ir[3:0]} : r_pc;
          if (IR_we) begin
            r_ir <= r_mbr;
`ifdef FU_INSTR_COUNT_EN
            r_instr_cnt <= r_instr_cnt + 16'd1;
`endif
          end
          if (MBR_we) begin
            if (MBR_mux) begin
              r_mbr <= RF_in;
            end else if (WAIT_CYCLES == 0) begin
              r_mbr <= ram_rdata;
            end else begin
              r_cnt   <= LP_CNT_INIT;
              r_state <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          // Strobes are dropped while a read is outstanding; the attempt is remembered.
          if (w_any_strobe) r_err <= 1'b1;
          if (r_cnt == 2'd0) begin
            r_mbr   <= ram_rdata;
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt - 2'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign ram_addr  = r_mar;
  assign ram_wdata = r_mbr;
  assign ram_we    = RAM_we & ~w_busy;
  assign IR_out    = r_ir;
  assign PC_out    = r_pc;
  assign FU_busy   = w_busy;
  assign FU_err    = r_err;
`ifdef FU_INSTR_COUNT_EN
  assign instr_cnt = r_instr_cnt;
`endif

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter: WAIT_CYCLES, default 1, RAM read latency in clock cycles (legal range 0..3).
REQ-002 FU_clk  in  1  sole clock; all state updates on rising edge.
REQ-003 FU_rst  in  1  asynchronous, active-high reset.
REQ-004 PC_inc  in  1  increment PC.
REQ-005 MAR_we  in  1  load MAR.
REQ-006 MAR_mux  in  1  MAR source: 0 = PC, 1 = {4'h0, IR[3:0]}.
REQ-007 MBR_we  in  1  load MBR.
REQ-008 MBR_mux  in  1  MBR source: 0 = RAM read data, 1 = RF_in.
REQ-009 IR_we  in  1  load IR from MBR.
REQ-010 RAM_we  in  1  store request from control unit.
REQ-011 RF_in  in  8  register-file data for stores.
REQ-012 ram_rdata  in  8  RAM read data.
REQ-013 ram_addr  out  8  RAM address, equal to MAR.
REQ-014 ram_wdata  out  8  RAM write data, equal to MBR.
REQ-015 ram_we  out  1  RAM write strobe.
REQ-016 IR_out  out  8  instruction register, feeds control-unit CU_in.
REQ-017 PC_out  out  8  program counter.
REQ-018 FU_busy  out  1  RAM read in progress; control unit must hold its state while high.
REQ-019 FU_err  out  1  sticky protocol-violation flag.

Function
REQ-020 Registers PC, MAR, MBR, IR SHALL be 8 bits; PC increments on PC_inc and wraps FF->00 with no flag.
REQ-021 MAR_we=1 SHALL load MAR from the source chosen by MAR_mux on the next edge; MAR_we with MAR_mux=0 and PC_inc in the same cycle SHALL load the pre-increment PC.
REQ-022 MBR_we=1 with MBR_mux=1 SHALL load RF_in on the next edge, no wait.
REQ-023 Read FSM states: IDLE, WAIT; MBR_we=1 with MBR_mux=0 in IDLE SHALL load the wait counter with WAIT_CYCLES-1 and enter WAIT, FU_busy high the following cycle.
REQ-024 In WAIT the counter SHALL decrement each cycle; at count 0, MBR <= ram_rdata and FSM -> IDLE, FU_busy low next cycle.
REQ-025 WAIT_CYCLES=0 SHALL capture ram_rdata on the same edge as the MBR_we request; FU_busy never asserts.
REQ-026 While FU_busy: MAR_we, MBR_we, IR_we and RAM_we SHALL be ignored and each SHALL set FU_err; PC_inc SHALL still be honoured.
REQ-027 IR_we=1 in IDLE SHALL load IR from the current MBR on the next edge.
REQ-028 ram_we SHALL equal RAM_we & ~FU_busy combinationally; ram_addr/ram_wdata are direct register outputs.
REQ-029 MBR_we and IR_we in the same IDLE cycle: IR gets the old MBR value.
REQ-030 FU_err SHALL remain set until reset.

Reset
REQ-031 FU_rst SHALL immediately clear PC, MAR, MBR, IR, counter, FU_err to 0 and force IDLE; FU_busy, ram_we = 0.
REQ-032 Reset asserted during WAIT SHALL abandon the read; no MBR capture after release.
REQ-033 First edge after reset release SHALL honour strobes normally.

Configuration
REQ-034 Macro FU_INSTR_COUNT_EN: defined -> extra output instr_cnt (16 bits), incremented on each accepted IR_we, wraps FFFF->0000, cleared by reset; undefined -> port and counter absent, all other behaviour identical.

Verification
REQ-035 Reset, then 3 cycles PC_inc -> PC_out=03; with PC=FF, PC_inc -> PC_out=00.
REQ-036 WAIT_CYCLES=2, MAR=10, ram_rdata=A5, MBR_we/MBR_mux=0 -> FU_busy high 2 cycles, MBR=A5 after, then IR_we -> IR_out=A5.
REQ-037 IR=0x07, MAR_we with MAR_mux=1 -> ram_addr=07; RF_in=3C, MBR_we/MBR_mux=1 then RAM_we -> ram_wdata=3C, ram_we high 1 cycle.
REQ-038 IR_we pulsed during FU_busy -> IR unchanged, FU_err=1 and stays 1.
REQ-039 FU_rst asserted mid-WAIT -> FU_busy=0 and all registers 0 immediately; MBR stays 0 after release.
REQ-040 With FU_INSTR_COUNT_EN defined, 5 accepted IR_we plus 1 during busy -> instr_cnt=5.
